knapsack_traceback: RTL and testbench

- Streaming 0/1 knapsack solver. Accepts an item list over a valid/ready write channel and runs the reverse-capacity DP.
- Records a per-item "take" bit for every capacity cell, then walks back through those bits to recover the chosen items.
- Emits the chosen item indices over a valid/ready read channel, together with the best value.
- Sits on the consumer side of the knapsack datapath: it supplies the item selection, not only the optimum value.

---
 rtl/knapsack_traceback_if.sv | 46 ++++
 rtl/knapsack_traceback.sv | 255 +++++++++++++++++++++++++
 tb/tb_knapsack_traceback.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knapsack_traceback_if.sv
// ---------------------------------------------------------------------------
// knapsack_traceback_if
//   Groups the two streaming channels of the knapsack traceback solver.
//
//   Item write channel (producer -> solver):
//     item_valid   beat valid
//     item_ready   solver accepts the beat
//     item_weight  item weight
//     item_value   item value
//     item_last    final item of the job
//
//   Selection read channel (solver -> consumer):
//     sel_valid    selected-index beat valid
//     sel_ready    consumer accepts the beat
//     sel_index    index of a chosen item (0-based, load order)
//     sel_last     final selected index of the job
//
//   Modports:
//     master  the item producer / selection consumer (e.g. a testbench)
//     slave   the solver itself
// ---------------------------------------------------------------------------
interface knapsack_traceback_if #(
    parameter int W_W = 8,
    parameter int V_W = 16
);
    logic           item_valid;
    logic           item_ready;
    logic [W_W-1:0] item_weight;
    logic [V_W-1:0] item_value;
    logic           item_last;

    logic           sel_valid;
    logic           sel_ready;
    logic [W_W-1:0] sel_index;
    logic           sel_last;

    modport master (
        output item_valid, item_weight, item_value, item_last, sel_ready,
        input  item_ready, sel_valid, sel_index, sel_last
    );

    modport slave (
        input  item_valid, item_weight, item_value, item_last, sel_ready,
        output item_ready, sel_valid, sel_index, sel_last
    );
endinterface

// File: rtl/knapsack_traceback.sv
// ---------------------------------------------------------------------------
// knapsack_traceback
//   Streaming 0/1 knapsack solver with item-selection recovery.
//   Loads an item list, runs the reverse-capacity DP one cell per cycle while
//   recording a take bit per (item, capacity) cell, then walks the take bits
//   from the last item down to recover the chosen items and streams their
//   indices out in strictly descending order.
//
//   Ports:
//     clk           rising-edge clock
//     reset_n       asynchronous active-low reset
//     start         one-cycle job start, honoured in IDLE and DONE
//     cfg_capacity  knapsack capacity, saturated to MAX_CAPACITY-1
//     bus           item write channel / selection read channel (slave side)
//     best_value    optimum value, valid while done=1
//     sel_count     number of chosen items, valid while done=1
//     busy          high in every state except IDLE
//     done          high in DONE
// ---------------------------------------------------------------------------
module knapsack_traceback #(
    parameter int MAX_CAPACITY = 60,
    parameter int MAX_ITEMNUM  = 60,
    parameter int W_W          = 8,
    parameter int V_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [W_W-1:0]        cfg_capacity,
    knapsack_traceback_if.slave   bus,
    output logic [V_W-1:0]        best_value,
    output logic [W_W-1:0]        sel_count,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (MAX_CAPACITY > 1) ? $clog2(MAX_CAPACITY) : 1;
    localparam int IW = (MAX_ITEMNUM > 1) ? $clog2(MAX_ITEMNUM) : 1;
    localparam int NW = $clog2(MAX_ITEMNUM + 1);

    localparam logic [W_W-1:0] CAP_LIMIT = W_W'(MAX_CAPACITY);
    localparam logic [W_W-1:0] CAP_TOP   = W_W'(MAX_CAPACITY - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        OUTER,
        INNER,
        TRACE,
        EMIT,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [NW-1:0]           r_itemCount;
    logic [IW-1:0]           r_item;
    logic [CW-1:0]           r_cap;
    logic [CW-1:0]           r_cell;
    logic [W_W-1:0]          r_curWeight;
    logic [V_W-1:0]          r_curValue;
    logic [V_W-1:0]          r_bestValue;
    logic [W_W-1:0]          r_selCount;

    logic [W_W-1:0]          r_weight [MAX_ITEMNUM];
    logic [V_W-1:0]          r_value  [MAX_ITEMNUM];
    logic [V_W-1:0]          r_dp     [MAX_CAPACITY];
    logic [MAX_CAPACITY-1:0] r_take   [MAX_ITEMNUM];

    logic [W_W-1:0] w_capSatFull;
    logic [CW-1:0]  w_capSat;
    logic           w_loadFire;
    logic           w_loadEnd;
    logic           w_lastItem;
    logic           w_fits;
    logic [CW-1:0]  w_srcIdx;
    logic [V_W-1:0] w_cand;
    logic           w_takeCell;
    logic [V_W-1:0] w_cellNew;
    logic           w_traceTake;
    logic [CW-1:0]  w_traceCell;
    logic           w_moreAhead;
    logic           w_startOk;
    logic           w_emitFire;

    // Capacities beyond the DP array fold onto the top cell.
    assign w_capSatFull = (cfg_capacity >= CAP_LIMIT) ? CAP_TOP : cfg_capacity;
    assign w_capSat     = w_capSatFull[CW-1:0];

    assign w_startOk  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_loadFire = (r_state == LOAD) && bus.item_valid;
    assign w_loadEnd  = w_loadFire &&
                        (bus.item_last || (r_itemCount == NW'(MAX_ITEMNUM - 1)));
    assign w_lastItem = (NW'(r_item) == (r_itemCount - NW'(1)));
    assign w_emitFire = (r_state == EMIT) && bus.sel_ready;

    // DP cell update. The reverse scan over capacity means dp[c-w] still holds
    // the previous item's value when cell c is processed, so no second buffer
    // is needed. Only a strictly larger candidate takes the item.
    assign w_fits     = (W_W'(r_cell) >= r_curWeight);
    assign w_srcIdx   = CW'(W_W'(r_cell) - r_curWeight);
    assign w_cand     = r_dp[w_srcIdx] + r_curValue;
    assign w_takeCell = w_fits && (w_cand > r_dp[r_cell]);
    assign w_cellNew  = w_takeCell ? w_cand : r_dp[r_cell];

    assign w_traceTake = r_take[r_item][r_cell];
    assign w_traceCell = CW'(W_W'(r_cell) - r_weight[r_item]);

    // Lookahead for sel_last: any lower item still taken at the already
    // reduced capacity means another beat will follow.
    always_comb begin
        w_moreAhead = 1'b0;
        for (int j = 0; j < MAX_ITEMNUM; j++) begin
            if ((IW'(j) < r_item) && r_take[j][r_cell]) begin
                w_moreAhead = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (start) w_nextState = LOAD;
            LOAD:  if (w_loadEnd) w_nextState = OUTER;
            OUTER: w_nextState = INNER;
            INNER: begin
                // The final item jumps straight to TRACE so the DP phase is
                // exactly n*(C+2) cycles.
                if (r_cell == '0) begin
                    w_nextState = w_lastItem ? TRACE : OUTER;
                end
            end
            TRACE: begin
                if (w_traceTake) begin
                    w_nextState = EMIT;
                end else if (r_item == '0) begin
                    w_nextState = DONE;
                end
            end
            EMIT: begin
                if (bus.sel_ready) begin
                    w_nextState = (r_item == '0) ? DONE : TRACE;
                end
            end
            DONE:  if (start) w_nextState = LOAD;
            default: w_nextState = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        bus.item_ready = (r_state == LOAD);
        bus.sel_valid  = (r_state == EMIT);
        bus.sel_index  = (r_state == EMIT) ? W_W'(r_item) : '0;
        bus.sel_last   = (r_state == EMIT) && !w_moreAhead;
        busy           = (r_state != IDLE);
        done           = (r_state == DONE);
        best_value     = r_bestValue;
        sel_count      = r_selCount;
    end

    // Datapath: item store, DP array, take bits and traceback registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_itemCount <= '0;
            r_item      <= '0;
            r_cap       <= '0;
            r_cell      <= '0;
            r_curWeight <= '0;
            r_curValue  <= '0;
            r_bestValue <= '0;
            r_selCount  <= '0;
            for (int k = 0; k < MAX_ITEMNUM; k++) begin
                r_weight[k] <= '0;
                r_value[k]  <= '0;
                r_take[k]   <= '0;
            end
            for (int k = 0; k < MAX_CAPACITY; k++) begin
                r_dp[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_startOk) begin
                        r_itemCount <= '0;
                        r_cap       <= w_capSat;
                        r_bestValue <= '0;
                        r_selCount  <= '0;
                        for (int k = 0; k < MAX_CAPACITY; k++) begin
                            r_dp[k] <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (w_loadFire) begin
                        r_weight[r_itemCount[IW-1:0]] <= bus.item_weight;
                        r_value[r_itemCount[IW-1:0]]  <= bus.item_value;
                        r_itemCount                   <= r_itemCount + NW'(1);
                    end
                    if (w_loadEnd) begin
                        r_item <= '0;
                    end
                end
                OUTER: begin
                    r_curWeight <= r_weight[r_item];
                    r_curValue  <= r_value[r_item];
                    r_cell      <= r_cap;
                end
                INNER: begin
                    r_dp[r_cell]           <= w_cellNew;
                    r_take[r_item][r_cell] <= w_takeCell;
                    if (r_cell == '0) begin
                        if (w_lastItem) begin
                            // When C=0 the top cell is the one being written
                            // this cycle, so take the fresh value.
                            r_bestValue <= (r_cell == r_cap) ? w_cellNew : r_dp[r_cap];
                            r_cell      <= r_cap;
                        end else begin
                            r_item <= r_item + IW'(1);
                        end
                    end else begin
                        r_cell <= r_cell - CW'(1);
                    end
                end
                TRACE: begin
                    if (w_traceTake) begin
                        r_cell     <= w_traceCell;
                        r_selCount <= r_selCount + W_W'(1);
                    end else if (r_item != '0) begin
                        r_item <= r_item - IW'(1);
                    end
                end
                EMIT: begin
                    if (w_emitFire && (r_item != '0)) begin
                        r_item <= r_item - IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knapsack_traceback.sv
// ---------------------------------------------------------------------------
// tb_knapsack_traceback
//   Directed bench for knapsack_traceback. A behavioural table-based DP with
//   traceback predicts the selection of each job; the expected beats are
//   queued when a job is launched and popped as the DUT emits them.
// ---------------------------------------------------------------------------
module tb_knapsack_traceback;

    localparam int W_W = 8;
    localparam int V_W = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [W_W-1:0] cfg_capacity = '0;
    logic [V_W-1:0] best_value;
    logic [W_W-1:0] sel_count;
    logic           busy;
    logic           done;

    knapsack_traceback_if #(.W_W(W_W), .V_W(V_W)) bus ();

    knapsack_traceback dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .cfg_capacity (cfg_capacity),
        .bus          (bus),
        .best_value   (best_value),
        .sel_count    (sel_count),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] idx;
        logic       last;
    } beat_t;

    int    assertCount = 0;
    int    failCount   = 0;
    beat_t expQ[$];
    int    gotIdx[$];
    int    itemW[64];
    int    itemV[64];
    int    itemN;
    int    expBest;
    int    expCount;
    int    sumW;
    int    sumV;

    logic [15:0] mdp   [0:64][0:63];
    bit          mtake [0:63][0:63];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: full 2-D DP table, then traceback from the last item.
    task automatic buildModel(input int cap);
        int          c;
        int          sel[$];
        logic [15:0] cand;
        beat_t       b;
        expQ.delete();
        for (int k = 0; k < 64; k++) mdp[0][k] = '0;
        for (int i = 0; i < itemN; i++) begin
            for (int k = 0; k <= cap; k++) begin
                mdp[i+1][k]  = mdp[i][k];
                mtake[i][k]  = 1'b0;
                if (k >= itemW[i]) begin
                    cand = mdp[i][k - itemW[i]] + 16'(itemV[i]);
                    if (cand > mdp[i][k]) begin
                        mdp[i+1][k] = cand;
                        mtake[i][k] = 1'b1;
                    end
                end
            end
        end
        expBest = int'(mdp[itemN][cap]);
        c = cap;
        for (int i = itemN - 1; i >= 0; i--) begin
            if (mtake[i][c]) begin
                sel.push_back(i);
                c = c - itemW[i];
            end
        end
        expCount = sel.size();
        for (int k = 0; k < sel.size(); k++) begin
            b.idx  = 8'(sel[k]);
            b.last = (k == sel.size() - 1);
            expQ.push_back(b);
        end
    endtask

    task automatic setCase1();
        itemN = 4;
        itemW[0] = 2; itemV[0] = 3;
        itemW[1] = 3; itemV[1] = 4;
        itemW[2] = 4; itemV[2] = 5;
        itemW[3] = 5; itemV[3] = 6;
    endtask

    // Starts a job, streams the items and optionally measures the DP phase
    // as the edge count from the last item handshake to best_value updating.
    task automatic applyStimulus(input int cap, input bit measure, input int expCycles);
        int guard;
        int cycles;
        buildModel(cap);
        gotIdx.delete();
        sumW = 0;
        sumV = 0;
        @(negedge clk);
        start        = 1'b1;
        cfg_capacity = 8'(cap);
        @(negedge clk);
        start        = 1'b0;
        for (int k = 0; k < itemN; k++) begin
            bus.item_valid  = 1'b1;
            bus.item_weight = 8'(itemW[k]);
            bus.item_value  = 16'(itemV[k]);
            bus.item_last   = (k == itemN - 1);
            guard = 0;
            while (!bus.item_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) checkOutput("item_ready timeout", 0, 1);
            @(posedge clk);
            #1;
            if (k != itemN - 1) @(negedge clk);
        end
        bus.item_valid = 1'b0;
        bus.item_last  = 1'b0;
        checkOutput("item_ready after last", bus.item_ready, 0);
        if (measure) begin
            cycles = 0;
            while (best_value === '0 && cycles < 5000) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            checkOutput("dp latency", cycles, expCycles);
        end
    endtask

    task automatic collectBeats(input int stall);
        int    guard;
        beat_t e;
        logic [7:0] holdIdx;
        logic       holdLast;
        guard = 0;
        bus.sel_ready = 1'b0;
        while (!done && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (bus.sel_valid) begin
                holdIdx  = bus.sel_index;
                holdLast = bus.sel_last;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    checkOutput("stall sel_valid", bus.sel_valid, 1);
                    checkOutput("stall sel_index", bus.sel_index, holdIdx);
                    checkOutput("stall sel_last", bus.sel_last, holdLast);
                end
                if (expQ.size() == 0) begin
                    checkOutput("unexpected beat", bus.sel_index, 255);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sel_index", bus.sel_index, e.idx);
                    checkOutput("sel_last", bus.sel_last, e.last);
                end
                if (gotIdx.size() > 0)
                    checkOutput("descending order", (int'(bus.sel_index) < gotIdx[$]), 1);
                gotIdx.push_back(int'(bus.sel_index));
                sumW += itemW[bus.sel_index];
                sumV += itemV[bus.sel_index];
                bus.sel_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.sel_ready = 1'b0;
            end
        end
        checkOutput("done reached", done, 1);
        checkOutput("beats outstanding", expQ.size(), 0);
        checkOutput("best_value vs model", best_value, expBest);
        checkOutput("sel_count vs model", sel_count, expCount);
        checkOutput("busy in DONE", busy, 1);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " best_value"}, best_value, 0);
        checkOutput({tag, " sel_count"}, sel_count, 0);
        checkOutput({tag, " sel_valid"}, bus.sel_valid, 0);
        checkOutput({tag, " item_ready"}, bus.item_ready, 0);
    endtask

    initial begin
        bus.item_valid  = 1'b0;
        bus.item_weight = '0;
        bus.item_value  = '0;
        bus.item_last   = 1'b0;
        bus.sel_ready   = 1'b0;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        checkIdleOutputs("idle");

        $display("[TB] case 1: C=5, four items");
        setCase1();
        applyStimulus(5, 1'b1, 28);
        collectBeats(0);
        checkOutput("case1 best", best_value, 7);
        checkOutput("case1 count", sel_count, 2);
        checkOutput("case1 beats", gotIdx.size(), 2);
        if (gotIdx.size() == 2) begin
            checkOutput("case1 first idx", gotIdx[0], 1);
            checkOutput("case1 second idx", gotIdx[1], 0);
        end

        $display("[TB] case 2: tie");
        itemN = 2;
        itemW[0] = 2; itemV[0] = 5;
        itemW[1] = 2; itemV[1] = 5;
        applyStimulus(2, 1'b0, 0);
        collectBeats(0);
        checkOutput("case2 best", best_value, 5);
        checkOutput("case2 beats", gotIdx.size(), 1);
        if (gotIdx.size() == 1) checkOutput("case2 idx", gotIdx[0], 0);

        $display("[TB] case 3: twenty items");
        begin
            int w3[20] = '{2,5,10,9,3,6,2,2,6,8,2,3,3,2,9,8,2,10,8,6};
            int v3[20] = '{8,1,5,9,5,6,8,2,3,7,5,4,3,7,6,7,9,3,10,5};
            itemN = 20;
            for (int k = 0; k < 20; k++) begin
                itemW[k] = w3[k];
                itemV[k] = v3[k];
            end
        end
        applyStimulus(20, 1'b0, 0);
        collectBeats(0);
        checkOutput("case3 best", best_value, 49);
        checkOutput("case3 weight fits", (sumW <= 20), 1);
        checkOutput("case3 value sum", sumV, 49);
        checkOutput("case3 count matches beats", sel_count, gotIdx.size());

        $display("[TB] case 4: nothing fits");
        itemN = 1;
        itemW[0] = 2; itemV[0] = 9;
        applyStimulus(1, 1'b0, 0);
        collectBeats(0);
        checkOutput("case4 best", best_value, 0);
        checkOutput("case4 count", sel_count, 0);
        checkOutput("case4 beats", gotIdx.size(), 0);
        checkOutput("case4 done", done, 1);

        $display("[TB] case 5: stalled consumer");
        setCase1();
        applyStimulus(5, 1'b0, 0);
        collectBeats(10);
        checkOutput("stall best", best_value, 7);
        checkOutput("stall beats", gotIdx.size(), 2);
        if (gotIdx.size() == 2) begin
            checkOutput("stall first idx", gotIdx[0], 1);
            checkOutput("stall second idx", gotIdx[1], 0);
        end

        $display("[TB] case 6: reset during DP");
        setCase1();
        applyStimulus(5, 1'b0, 0);
        repeat (5) @(negedge clk);
        checkOutput("busy before abort", busy, 1);
        reset_n = 1'b0;
        #2;
        checkIdleOutputs("abort");
        @(negedge clk);
        checkIdleOutputs("abort hold");
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle after abort", busy, 0);
        setCase1();
        applyStimulus(5, 1'b1, 28);
        collectBeats(0);
        checkOutput("rerun best", best_value, 7);
        checkOutput("rerun beats", gotIdx.size(), 2);
        if (gotIdx.size() == 2) begin
            checkOutput("rerun first idx", gotIdx[0], 1);
            checkOutput("rerun second idx", gotIdx[1], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
